// File: rtl/imem_loader.sv
// UART-framed instruction-memory loader: parses SYNC/count/data/checksum frames,
// writes assembled 32-bit words to the memory and holds the core off it meanwhile.
module imem_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         DEPTH     = 64,
  parameter int         TIMEOUT   = 100000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] pc,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_hold,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   last_q, last_d;          // N-1, so a full DEPTH frame fits in AW bits
  logic [AW-1:0]   word_idx_q, word_idx_d;
  logic [AW-1:0]   word_idx_wr_q, word_idx_wr_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     wd_q, wd_d;
  logic [TW-1:0]   gap_q, gap_d;
  logic            we_q, we_d;
  logic            hold_q, hold_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  always_comb begin
    // NOTE: every next-state variable is defaulted first so no path infers a latch.
    state_d       = state_q;
    last_d        = last_q;
    word_idx_d    = word_idx_q;
    word_idx_wr_d = word_idx_wr_q;
    byte_idx_d    = byte_idx_q;
    csum_d        = csum_q;
    word_d        = word_q;
    wd_d          = wd_q;
    hold_d        = hold_q;
    we_d          = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    gap_d         = (state_q == IDLE || rx_valid) ? '0 : gap_q + TW'(1);

    unique case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = COUNT;
          hold_d  = 1'b1;
        end
      end
      COUNT: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || int'(rx_data) > DEPTH) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            last_d     = AW'(int'(rx_data) - 1);
            word_idx_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          csum_d     = csum_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d          = 1'b1;
            wd_d          = {rx_data, word_q[23:0]};
            word_idx_wr_d = word_idx_q;
            word_idx_d    = word_idx_q + AW'(1);
            if (word_idx_q == last_q) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (rx_valid) begin
          state_d = IDLE;
          if (rx_data == csum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Stalled stream: abandon the frame but keep the core held off a partial image.
    if (state_q != IDLE && !rx_valid && gap_q == TW'(TIMEOUT - 1)) begin
      err_d   = 1'b1;
      state_d = IDLE;
      gap_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      last_q        <= '0;
      word_idx_q    <= '0;
      word_idx_wr_q <= '0;
      byte_idx_q    <= '0;
      csum_q        <= '0;
      word_q        <= '0;
      wd_q          <= '0;
      gap_q         <= '0;
      we_q          <= 1'b0;
      hold_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      word_idx_q    <= word_idx_d;
      word_idx_wr_q <= word_idx_wr_d;
      byte_idx_q    <= byte_idx_d;
      csum_q        <= csum_d;
      word_q        <= word_d;
      wd_q          <= wd_d;
      gap_q         <= gap_d;
      we_q          <= we_d;
      hold_q        <= hold_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign imem_we   = we_q;
  assign imem_wd   = wd_q;
  assign imem_addr = hold_q ? 32'({word_idx_wr_q, 2'b00}) : pc;
  assign core_hold = hold_q;
  assign busy      = (state_q != IDLE);
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random frames against a queue of expected
// memory writes derived from the frame format, plus directed error/timeout/reset cases.
module tb_imem_loader;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         DEPTH   = 64;
  localparam int         TIMEOUT = 300;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] pc;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        core_hold;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int tests = 0;
  int fails = 0;
  int n_we = 0, n_done = 0, n_err = 0;
  logic [63:0] exp_q[$];   // {addr, data} of each write the frames should produce

  imem_loader #(.SYNC_BYTE(SYNC), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .rx_data(rx_data), .rx_valid(rx_valid), .pc(pc),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .core_hold(core_hold), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (imem_we) begin
      n_we++;
      check("we_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("we_addr", imem_addr, e[63:32]);
        check("we_data", imem_wd, e[31:0]);
      end
    end
    if (!core_hold) check("addr_pc", imem_addr, pc);
    if (load_done) n_done++;
    if (load_err) n_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      rx_valid = 1'b0;
      @(posedge CLK); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  // Sends a frame of n random words; csum_flip != 0 corrupts the checksum byte.
  task automatic send_frame(input int n, input logic [7:0] csum_flip, input int max_gap);
    logic [7:0]  b[4];
    logic [7:0]  cs;
    logic [31:0] w;
    int          we0;
    we0 = n_we;
    send_byte(SYNC, $urandom_range(max_gap, 0));
    check("hold_rise", core_hold, 1);
    check("busy_rise", busy, 1);
    send_byte(8'(n), $urandom_range(max_gap, 0));
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b[j] = 8'($urandom);
        cs   = cs ^ b[j];
      end
      w = {b[3], b[2], b[1], b[0]};
      exp_q.push_back({32'(i * 4), w});
      for (int j = 0; j < 4; j++) send_byte(b[j], $urandom_range(max_gap, 0));
    end
    send_byte(cs ^ csum_flip, $urandom_range(max_gap, 0));
    if (csum_flip == 8'h00) begin
      check("done_pulse", load_done, 1);
      check("done_hold_fall", core_hold, 0);
    end else begin
      check("csum_err_pulse", load_err, 1);
      check("csum_err_hold", core_hold, 1);
    end
    check("frame_busy_end", busy, 0);
    check("frame_writes", 32'(n_we - we0), 32'(n));
    check("frame_queue_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic bad_count(input logic [7:0] cnt);
    int we0, err0;
    we0  = n_we;
    err0 = n_err;
    send_byte(SYNC, 0);
    send_byte(cnt, 0);
    check("badcnt_err", load_err, 1);
    check("badcnt_hold", core_hold, 1);
    check("badcnt_busy", busy, 0);
    @(negedge CLK); #1;
    check("badcnt_nowe", 32'(n_we - we0), 0);
    check("badcnt_one_err", 32'(n_err - err0), 1);
  endtask

  initial begin
    int waited, we0, done0, err0;
    logic hold0;
    RST_N    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    pc       = $urandom;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_we", imem_we, 0);
    check("rst_wd", imem_wd, 0);
    check("rst_hold", core_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_addr", imem_addr, pc);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Known single-word frame.
    exp_q.push_back({32'h0, 32'h00100093});
    send_byte(SYNC, 0);
    check("t1_hold_rise", core_hold, 1);
    send_byte(8'h01, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 1);
    send_byte(8'h10, 0);
    send_byte(8'h00, 2);
    check("t1_hold_mid", core_hold, 1);
    send_byte(8'h83, 0);
    check("t1_done", load_done, 1);
    check("t1_hold_fall", core_hold, 0);
    check("t1_queue", 32'(exp_q.size()), 0);

    // Full-depth frame, then pass-through.
    send_frame(DEPTH, 8'h00, 2);
    pc = 32'h40;
    @(posedge CLK); #1;
    check("idle_addr_pc", imem_addr, 32'h40);

    // Bad counts, then a good frame releases the core.
    bad_count(8'h00);
    bad_count(8'(DEPTH + 1));
    send_frame(int'($urandom_range(8, 1)), 8'h00, 1);

    // Corrupted checksum: writes land, error, hold sticky.
    send_frame(2, 8'h01, 1);

    // Stalled stream.
    send_byte(SYNC, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    waited = 0;
    while (!load_err && waited < TIMEOUT + 10) begin
      @(posedge CLK); #1;
      waited++;
    end
    check("timeout_err", load_err, 1);
    check("timeout_not_early", 32'(waited >= TIMEOUT), 1);
    check("timeout_busy", busy, 0);
    check("timeout_hold", core_hold, 1);

    // Stray non-sync byte in IDLE.
    @(posedge CLK); #1;
    we0 = n_we; done0 = n_done; err0 = n_err; hold0 = core_hold;
    send_byte(8'h00, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("stray_busy", busy, 0);
    check("stray_hold", core_hold, hold0);
    check("stray_events", 32'((n_we - we0) + (n_done - done0) + (n_err - err0)), 0);

    // Random frames with random PCs in between.
    for (int k = 0; k < 4; k++) begin
      pc = $urandom;
      send_frame(int'($urandom_range(DEPTH, 1)), 8'h00, int'($urandom_range(2, 0)));
    end

    // Reset in the middle of DATA.
    pc = $urandom;
    exp_q.push_back({32'h0, 32'h44332211});
    send_byte(SYNC, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    check("prerst_busy", busy, 1);
    done0 = n_done; err0 = n_err;
    RST_N = 1'b0;
    #1;
    check("midrst_we", imem_we, 0);
    check("midrst_wd", imem_wd, 0);
    check("midrst_hold", core_hold, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pulses", {30'd0, load_done, load_err}, 0);
    check("midrst_addr", imem_addr, pc);
    check("midrst_queue", 32'(exp_q.size()), 0);
    exp_q.delete();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("midrst_no_pulse", 32'((n_done - done0) + (n_err - err0)), 0);
    send_frame(3, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

UART-driven programming controller for the instruction memory. Parses a framed byte stream from the UART receiver, assembles 32-bit words, and drives the memory's write port (WE/A/WD) while holding the core off the memory. Outside a load it passes the core PC straight through to the memory address. Sits between the UART RX, the core fetch path and the instruction memory.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- DEPTH, 64, instruction memory size in words; maximum word count per frame
- TIMEOUT, 100000, maximum inter-byte gap in CLK cycles before a frame is aborted

- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe: rx_data is valid
- pc  in  32  core fetch address
- imem_we  out  1  memory write enable
- imem_addr  out  32  memory address
- imem_wd  out  32  memory write data
- core_hold  out  1  core must stall/stay in reset while high
- busy  out  1  frame in progress
- load_done  out  1  one-cycle pulse: frame accepted
- load_err  out  1  one-cycle pulse: frame rejected

## Operation
- Frame: SYNC_BYTE, count N (1..DEPTH), N×4 data bytes (each word little-endian, byte 0 = bits 7:0), checksum = XOR of all 4N data bytes.
- States: IDLE, COUNT, DATA, CHECK.
- IDLE: rx_valid with rx_data==SYNC_BYTE -> COUNT and assert core_hold; any other byte is ignored.
- COUNT: N==0 or N>DEPTH -> error; otherwise latch N, clear word index, byte index and checksum -> DATA.
- DATA: each byte is shifted into the word register at lane byte_idx and XORed into the checksum. On the 4th byte, a write of the assembled word to word_idx is issued, word_idx increments and byte_idx clears. After the write of word N-1 -> CHECK.
- CHECK: byte == running checksum -> load_done, release core_hold, -> IDLE. Mismatch -> error.
- Error (bad count, bad checksum, or timeout): pulse load_err and return to IDLE. core_hold stays asserted (sticky) until a later frame completes successfully. Words already written are not rolled back.
- Timeout: the gap counter clears on every rx_valid and counts while in COUNT/DATA/CHECK. Reaching TIMEOUT -> error.
- Address mux, combinational: core_hold==0 -> imem_addr = pc. Otherwise imem_addr = {word_idx_wr, 2'b00}, where word_idx_wr is the registered write index.
- imem_wd = registered assembled word. Words beyond N are untouched.
- busy = state != IDLE.

## Timing
- Reset values: imem_we=0, imem_wd=0, core_hold=0, busy=0, load_done=0, load_err=0, state=IDLE, all counters 0. imem_addr = pc after reset.
- core_hold rises the cycle after the sync byte's rx_valid.
- imem_we is registered: a single-cycle pulse the cycle after the 4th byte's rx_valid, with imem_addr and imem_wd stable in that same cycle.
- A byte arriving in the same cycle as imem_we is accepted as byte 0 of the next word, so back-to-back rx_valid is supported.
- load_done/load_err pulse the cycle after the terminating byte (or after timeout expiry). core_hold falls in that same cycle on success.
- rx_valid in IDLE with a non-sync byte produces no output change.
- RST_N asserted mid-frame aborts immediately, with all outputs at reset values and no pulse. The partial image remains in memory.
- Checksum and word arithmetic are 8-bit/32-bit with no carries. word_idx width is clog2(DEPTH).

## Test plan
- Reset, then frame A5,01,93,00,10,00,checksum 83 -> one imem_we with addr 0 and wd 0x00100093; load_done pulse; core_hold high from sync+1 until load_done.
- 64-word frame with correct checksum -> 64 imem_we pulses at addresses 0x00..0xFC, then load_done. Idle afterwards: imem_addr tracks pc=0x40.
- Count byte 0x00, and separately 0x41 -> load_err, no imem_we, core_hold stays 1. A following valid frame clears core_hold.
- 2-word frame with the checksum XORed by 0x01 -> two writes occur, then load_err, and core_hold remains 1.
- Stop the stream after 2 data bytes and wait TIMEOUT cycles -> load_err, state IDLE. Stray byte 0x00 in IDLE -> no effect.
- Assert RST_N=0 mid-DATA -> all outputs at reset values immediately, core_hold=0, imem_addr=pc.
